// File: rtl/sawtooth_freq_detector_if.sv
// Sample-strobe input and frequency-estimate output bundle for sawtooth_freq_detector.
// valid_out is a one-cycle pulse with no ready: the consumer must capture outputs on that cycle.
interface sawtooth_freq_detector_if #(
    parameter int PERIOD_W = 24
);
    logic                step_in;
    logic signed [31:0]  amp_in;
    logic [31:0]         phase_incr_out;
    logic [PERIOD_W-1:0] period_out;
    logic                valid_out;
    logic                locked_out;
    logic                overflow_out;

    modport master (
        output step_in, amp_in,
        input  phase_incr_out, period_out, valid_out, locked_out, overflow_out
    );

    modport slave (
        input  step_in, amp_in,
        output phase_incr_out, period_out, valid_out, locked_out, overflow_out
    );
endinterface

// File: rtl/sawtooth_freq_detector.sv
// Recovers the oscillator phase increment (2^32 / period) from a sawtooth sample stream.
// Define SAWDET_AVG_EN to average four consecutive periods before each divide.
module sawtooth_freq_detector #(
    parameter int PERIOD_W   = 24,
    parameter int MIN_PERIOD = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    sawtooth_freq_detector_if.slave bus,
    output logic [1:0]              dbg_state_o
);
`ifdef SAWDET_AVG_EN
    localparam int DIV_W = PERIOD_W + 2;
    localparam logic [DIV_W-1:0] REM_INIT = DIV_W'(4);
`else
    localparam int DIV_W = PERIOD_W;
    localparam logic [DIV_W-1:0] REM_INIT = DIV_W'(1);
`endif
    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DIVIDE, S_DONE} state_e;

    state_e              state_q;
    logic                sign_q, sign_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                sat_q, sat_d, sat_set;
    logic [DIV_W-1:0]    div_q, rem_q, rem_low, rem_d;
    logic                quo_bit;
    logic [31:0]         quo_q, phase_q;
    logic [4:0]          iter_q;
    logic [PERIOD_W-1:0] period_q, p;
    logic                valid_q, locked_q, ovf_q;
    logic                wrap, too_short, unused_amp;
`ifdef SAWDET_AVG_EN
    logic [DIV_W-1:0]    acc_q, acc_sum;
    logic [1:0]          acc_n_q;
    assign acc_sum = acc_q + DIV_W'(p);
`endif

    assign wrap       = bus.step_in & ~sign_q & bus.amp_in[31];
    assign unused_amp = ^bus.amp_in[30:0];
    // Only meaningful when not saturated, so cnt_q + 1 cannot wrap here.
    assign p          = cnt_q + PERIOD_W'(1);
    assign too_short  = p < PERIOD_W'(MIN_PERIOD);

    always_comb begin
        sign_d  = sign_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        sat_set = 1'b0;
        if (bus.step_in) begin
            sign_d = bus.amp_in[31];
            if (wrap) begin
                cnt_d = '0;
                sat_d = 1'b0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + PERIOD_W'(1);
                if (cnt_d == CNT_MAX) begin
                    sat_d   = 1'b1;
                    sat_set = 1'b1;
                end
            end
        end
    end

    // Remainder stays below the divisor, so the shifted-out MSB alone forces a subtract
    // and the modular difference is exact.
    assign rem_low = {rem_q[DIV_W-2:0], 1'b0};
    assign quo_bit = rem_q[DIV_W-1] | (rem_low >= div_q);
    assign rem_d   = quo_bit ? rem_low - div_q : rem_low;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b1;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            div_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            iter_q   <= '0;
            phase_q  <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef SAWDET_AVG_EN
            acc_q    <= '0;
            acc_n_q  <= '0;
`endif
        end else begin
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            case (state_q)
                S_IDLE: if (wrap) state_q <= S_COUNT;
                S_COUNT: begin
                    if (wrap) begin
                        if (sat_q || too_short) begin
                            ovf_q    <= sat_q;
                            locked_q <= 1'b0;
`ifdef SAWDET_AVG_EN
                            acc_q    <= '0;
                            acc_n_q  <= '0;
                        end else if (acc_n_q != 2'd3) begin
                            acc_q    <= acc_sum;
                            acc_n_q  <= acc_n_q + 2'd1;
                        end else begin
                            div_q    <= acc_sum;
                            acc_q    <= '0;
                            acc_n_q  <= '0;
                            rem_q    <= REM_INIT;
                            iter_q   <= '0;
                            state_q  <= S_DIVIDE;
                        end
`else
                        end else begin
                            div_q    <= p;
                            rem_q    <= REM_INIT;
                            iter_q   <= '0;
                            state_q  <= S_DIVIDE;
                        end
`endif
                    end
                end
                S_DIVIDE: begin
                    rem_q  <= rem_d;
                    quo_q  <= {quo_q[30:0], quo_bit};
                    iter_q <= iter_q + 5'd1;
                    if (iter_q == 5'd31) state_q <= S_DONE;
`ifdef SAWDET_AVG_EN
                    if (wrap) begin
                        acc_q   <= '0;
                        acc_n_q <= '0;
                    end
`endif
                end
                S_DONE: begin
                    phase_q  <= quo_q;
`ifdef SAWDET_AVG_EN
                    period_q <= div_q[DIV_W-1:2];
                    if (wrap) begin
                        acc_q   <= '0;
                        acc_n_q <= '0;
                    end
`else
                    period_q <= div_q;
`endif
                    valid_q  <= 1'b1;
                    locked_q <= 1'b1;
                    state_q  <= S_COUNT;
                end
                default: state_q <= S_IDLE;
            endcase
            // A saturating counter means the estimate is stale even before a wrap arrives.
            if (sat_set) locked_q <= 1'b0;
        end
    end

    assign bus.phase_incr_out = phase_q;
    assign bus.period_out     = period_q;
    assign bus.valid_out      = valid_q;
    assign bus.locked_out     = locked_q;
    assign bus.overflow_out   = ovf_q;
    assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_sawtooth_freq_detector.sv
// Bench for sawtooth_freq_detector: vector table, hand sequences for multi-cycle corners,
// and randomized sawtooths compared every cycle against an event-level estimate model.
`timescale 1ns/1ps
module tb_sawtooth_freq_detector;
    localparam int PW_A  = 24;
    localparam int MIN_A = 2;
    localparam int PW_B  = 8;
    localparam int MIN_B = 4;
    localparam longint MAX_A = (longint'(1) << PW_A) - 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               step = 1'b0;
    logic signed [31:0] amp = '0;
    logic [1:0]         dbg_a, dbg_b;

    sawtooth_freq_detector_if #(.PERIOD_W(PW_A)) bus_a();
    sawtooth_freq_detector_if #(.PERIOD_W(PW_B)) bus_b();
    assign bus_a.step_in = step;
    assign bus_a.amp_in  = amp;
    assign bus_b.step_in = step;
    assign bus_b.amp_in  = amp;

    sawtooth_freq_detector #(.PERIOD_W(PW_A), .MIN_PERIOD(MIN_A)) dut_a (
        .clk_in(clk), .rst_in(rst_n), .bus(bus_a), .dbg_state_o(dbg_a));
    sawtooth_freq_detector #(.PERIOD_W(PW_B), .MIN_PERIOD(MIN_B)) dut_b (
        .clk_in(clk), .rst_in(rst_n), .bus(bus_b), .dbg_state_o(dbg_b));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick(input logic s, input logic signed [31:0] a);
        step = s;
        amp  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, amp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1'b0, '0);
        rst_n = 1'b1;
    endtask

    function automatic logic signed [31:0] saw_amp(input int per, input int k);
        int ph;
        ph = k % per;
        return 32'(-128 + (ph * 256) / per);
    endfunction

    task automatic feed_saw(input int per, input int gap, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            tick(1'b1, saw_amp(per, k));
            idle(gap - 1);
        end
    endtask

    task automatic seg(input int n);
        for (int i = 0; i < n - 1; i++) tick(1'b1, 32'sd64);
        tick(1'b1, -32'sd64);
    endtask

    // event-level model of dut_a: periods between wraps, busy window, estimate queue
    typedef struct {
        longint              t;
        logic [31:0]         phase;
        logic [PW_A-1:0]     period;
    } est_t;
    est_t   exp_q[$];
    longint acc_q[$];
    longint cyc = 0;
    bit     m_armed = 1'b0;
    longint m_nw = 0;
    longint m_busy = 0;
    logic   m_prev = 1'b1;
    logic [31:0]     m_phase = '0;
    logic [PW_A-1:0] m_period = '0;
    bit     m_locked = 1'b0, m_valid = 1'b0, m_ovf = 1'b0;

    always @(posedge clk) begin : model
        est_t   e;
        longint per, sum;
        bit     w;
        cyc++;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            m_armed = 1'b0; m_nw = 0; m_busy = 0; m_prev = 1'b1;
            m_phase = '0; m_period = '0; m_locked = 1'b0;
        end else begin
            if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
                e = exp_q.pop_front();
                m_phase = e.phase; m_period = e.period;
                m_valid = 1'b1; m_locked = 1'b1;
            end
            if (step) begin
                w = !m_prev && amp[31];
                m_prev = amp[31];
                if (w) begin
                    per = m_nw + 1;
                    if (!m_armed) m_armed = 1'b1;
                    else if (cyc < m_busy) acc_q.delete();
                    else if (m_nw >= MAX_A) begin
                        m_ovf = 1'b1; m_locked = 1'b0; acc_q.delete();
                    end else if (per < MIN_A) begin
                        m_locked = 1'b0; acc_q.delete();
                    end else begin
`ifdef SAWDET_AVG_EN
                        acc_q.push_back(per);
                        if (acc_q.size() == 4) begin
                            sum = acc_q[0] + acc_q[1] + acc_q[2] + acc_q[3];
                            e.t = cyc + 33;
                            e.phase = 32'((longint'(1) << 34) / sum);
                            e.period = PW_A'(sum / 4);
                            exp_q.push_back(e);
                            m_busy = cyc + 34;
                            acc_q.delete();
                        end
`else
                        sum = per;
                        e.t = cyc + 33;
                        e.phase = 32'((longint'(1) << 32) / sum);
                        e.period = PW_A'(per);
                        exp_q.push_back(e);
                        m_busy = cyc + 34;
`endif
                    end
                    m_nw = 0;
                end else begin
                    m_nw++;
                    if (m_nw == MAX_A) m_locked = 1'b0;
                end
            end
        end
    end

    // scoreboard: compare dut_a with the model every cycle, count pulses on both DUTs
    bit     chk_en = 1'b0;
    int     va_cnt = 0, vb_cnt = 0, ob_cnt = 0;
    longint va_first = -1;
    always @(negedge clk) begin
        if (bus_a.valid_out) begin
            va_cnt++;
            if (va_first < 0) va_first = cyc;
        end
        if (bus_b.valid_out) vb_cnt++;
        if (bus_b.overflow_out) ob_cnt++;
        if (chk_en) begin
            check("a_valid", 64'(bus_a.valid_out), 64'(m_valid));
            check("a_overflow", 64'(bus_a.overflow_out), 64'(m_ovf));
            check("a_locked", 64'(bus_a.locked_out), 64'(m_locked));
            check("a_phase", 64'(bus_a.phase_incr_out), 64'(m_phase));
            check("a_period", 64'(bus_a.period_out), 64'(m_period));
        end
    end

    typedef struct {
        int              per;
        int              gap;
        logic [31:0]     exp_phase;
        logic [PW_A-1:0] exp_period;
        int              exp_valids;
    } vec_t;

    initial begin : main
        vec_t   vecs[4];
        longint w2;
        vecs[0] = '{256, 1, 32'h01000000, 256, 2};
        vecs[1] = '{100, 4, 32'd42949672, 100, 2};
        vecs[2] = '{34,  1, 32'd126322567, 34, 2};
        vecs[3] = '{33,  1, 32'd130150524, 33, 1};

        do_reset();
        chk_en = 1'b1;
        check("rst_a_phase", 64'(bus_a.phase_incr_out), 0);
        check("rst_a_period", 64'(bus_a.period_out), 0);
        check("rst_a_locked", 64'(bus_a.locked_out), 0);
        check("rst_a_state", 64'(dbg_a), 0);
        check("rst_b_valid", 64'(bus_b.valid_out), 0);

`ifdef SAWDET_AVG_EN
        do_reset();
        va_cnt = 0;
        seg(5); seg(100); seg(100); seg(101); seg(101);
        idle(45);
        check("avg_valids", 64'(va_cnt), 1);
        check("avg_phase", 64'(bus_a.phase_incr_out), 64'd42735992);
        check("avg_period", 64'(bus_a.period_out), 100);
`else
        for (int v = 0; v < 4; v++) begin
            do_reset();
            va_cnt = 0;
            va_first = -1;
            feed_saw(vecs[v].per, vecs[v].gap, 0, 2 * vecs[v].per - 1);
            tick(1'b1, saw_amp(vecs[v].per, 2 * vecs[v].per));
            w2 = cyc;
            idle(vecs[v].gap - 1);
            feed_saw(vecs[v].per, vecs[v].gap, 2 * vecs[v].per + 1, 3 * vecs[v].per);
            idle(45);
            check($sformatf("vec%0d_valids", v), 64'(va_cnt), 64'(vecs[v].exp_valids));
            check($sformatf("vec%0d_latency", v), 64'(va_first - w2), 33);
            check($sformatf("vec%0d_phase", v), 64'(bus_a.phase_incr_out), 64'(vecs[v].exp_phase));
            check($sformatf("vec%0d_period", v), 64'(bus_a.period_out), 64'(vecs[v].exp_period));
            check($sformatf("vec%0d_locked", v), 64'(bus_a.locked_out), 1);
        end

        // short periods on the MIN_PERIOD=4 instance after a good lock
        do_reset();
        feed_saw(10, 1, 0, 30);
        idle(40);
        check("short_b_locked_before", 64'(bus_b.locked_out), 1);
        check("short_b_phase_before", 64'(bus_b.phase_incr_out), 64'd429496729);
        vb_cnt = 0;
        feed_saw(3, 1, 1, 2);
        check("short_b_locked_hold", 64'(bus_b.locked_out), 1);
        feed_saw(3, 1, 3, 3);
        check("short_b_locked_fall", 64'(bus_b.locked_out), 0);
        feed_saw(3, 1, 4, 15);
        idle(40);
        check("short_b_valids", 64'(vb_cnt), 0);
        check("short_b_phase_kept", 64'(bus_b.phase_incr_out), 64'd429496729);
        check("short_b_period_kept", 64'(bus_b.period_out), 10);

        // counter saturation on the PERIOD_W=8 instance
        do_reset();
        feed_saw(10, 1, 0, 20);
        idle(40);
        check("ovf_b_locked_before", 64'(bus_b.locked_out), 1);
        vb_cnt = 0;
        ob_cnt = 0;
        for (int i = 0; i < 254; i++) tick(1'b1, -32'sd10);
        check("ovf_b_locked_254", 64'(bus_b.locked_out), 1);
        tick(1'b1, -32'sd10);
        check("ovf_b_locked_255", 64'(bus_b.locked_out), 0);
        check("ovf_b_no_early_pulse", 64'(ob_cnt), 0);
        for (int i = 0; i < 44; i++) tick(1'b1, -32'sd10);
        tick(1'b1, 32'sd5);
        tick(1'b1, -32'sd5);
        check("ovf_b_pulse", 64'(bus_b.overflow_out), 1);
        tick(1'b0, amp);
        check("ovf_b_pulse_end", 64'(bus_b.overflow_out), 0);
        idle(40);
        check("ovf_b_count", 64'(ob_cnt), 1);
        check("ovf_b_valids", 64'(vb_cnt), 0);

        // reset ten cycles into a divide
        do_reset();
        va_cnt = 0;
        feed_saw(40, 1, 0, 80);
        idle(9);
        check("rdiv_a_state", 64'(dbg_a), 2);
        rst_n = 1'b0;
        tick(1'b0, amp);
        rst_n = 1'b1;
        check("rdiv_a_phase", 64'(bus_a.phase_incr_out), 0);
        check("rdiv_a_period", 64'(bus_a.period_out), 0);
        check("rdiv_a_locked", 64'(bus_a.locked_out), 0);
        idle(40);
        check("rdiv_a_no_valid", 64'(va_cnt), 0);
        feed_saw(40, 1, 1, 40);
        idle(40);
        check("rdiv_a_one_wrap", 64'(va_cnt), 0);
        feed_saw(40, 1, 41, 80);
        idle(40);
        check("rdiv_a_two_wraps", 64'(va_cnt), 1);
        check("rdiv_a_phase_new", 64'(bus_a.phase_incr_out), 64'd107374182);
`endif

        // randomized sawtooths against the model
        for (int r = 0; r < 16; r++) begin
            int per, gap, n, k0;
            per = $urandom_range(2, 90);
            gap = $urandom_range(1, 3);
            n   = $urandom_range(2, 6);
            k0  = $urandom_range(0, per - 1);
            if ($urandom_range(0, 7) == 0) do_reset();
            feed_saw(per, gap, k0, k0 + n * per);
            idle($urandom_range(0, 40));
        end
        idle(45);
        check("model_queue_drained", 64'(exp_q.size()), 0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sawtooth_freq_detector.md
# sawtooth_freq_detector

Measures the frequency of a sawtooth stream produced by the synth's phase-accumulator oscillators and reports it in the same 32-bit phase-increment units those oscillators consume, i.e. it recovers `PHASE_INCR` from `amp_out`. It sits on the sample strobe domain beside the oscillator bank and feeds tuner, auto-calibration and loopback-test logic. It counts sample strobes between sawtooth wraps, then runs a 32-cycle sequential restoring divide.

## Interface
- `PERIOD_W`, 24: width of the period counter; maximum measurable period is 2^PERIOD_W−1 steps.
- `MIN_PERIOD`, 2: shortest accepted period in steps (≥2); shorter periods are discarded.
- `clk_in` input 1: system clock.
- `rst_in` input 1: synchronous, active-low reset.
- `step_in` input 1: sample strobe; `amp_in` is sampled only when high.
- `amp_in` input 32 signed: sawtooth sample, two's complement, sign-extended 8-bit ramp −128..127.
- `phase_incr_out` output 32: latest estimate, floor(2^32 / period).
- `period_out` output PERIOD_W: latest accepted period in steps.
- `valid_out` output 1: one-cycle pulse when both estimate outputs update.
- `locked_out` output 1: high while the estimate is current.
- `overflow_out` output 1: one-cycle pulse when a period exceeded the counter range.

## Operation
- Wrap detection is on sampled strobes only: wrap = previous sampled sign bit 0 and `amp_in[31]` = 1. The previous-sign register resets to 1, so the first sample never wraps.
- Period counter `cnt`:
  - cleared to 0 on a wrap step;
  - incremented on each non-wrap step;
  - saturates at 2^PERIOD_W−1 and sets a sticky `sat` flag.
  - At a wrap, the measured period P = `cnt`+1, i.e. strobes from the previous wrap (exclusive) to this wrap (inclusive).
- FSM:
  - IDLE: waits for the first wrap, then goes to COUNT. There is no measurement on the first wrap.
  - COUNT, on a wrap step:
    - if `sat`: pulse `overflow_out`, clear `locked_out`, restart counting, stay in COUNT;
    - else if P < MIN_PERIOD: discard, clear `locked_out`, stay in COUNT;
    - else latch P as divisor and go to DIVIDE.
  - DIVIDE: restoring divider, one quotient bit per cycle, 32 cycles, then DONE. The counter keeps running. A wrap arriving during DIVIDE restarts the counter normally, but that period is dropped (no divide, no flag).
  - DONE, one cycle:
    - `phase_incr_out` ← quotient, `period_out` ← P;
    - `valid_out` = 1, `locked_out` ← 1;
    - return to COUNT.
- `sat` clears at every wrap.
- `locked_out` also clears whenever `sat` becomes set mid-count; timeout does not wait for a wrap.
- Outputs hold their value between updates.

## Timing
- Reset (`rst_in` = 0 at an edge): the next state has `phase_incr_out` = 0, `period_out` = 0, `valid_out` = 0, `locked_out` = 0, `overflow_out` = 0, FSM in IDLE, `cnt` = 0, `sat` = 0, previous sign = 1.
- Reset mid-DIVIDE aborts the divide with no `valid_out`.
- Latency: wrap step sampled at edge T → divide iterations at edges T+1..T+32 → `valid_out` and the updated outputs visible after edge T+33, high for exactly one cycle.
- `overflow_out` is visible after edge T, where T is the wrap edge.
- `step_in` may be high every cycle. With periods < 34 steps, every other measurement is dropped.
- No backpressure: a consumer must capture on `valid_out`.

## Configuration
- `SAWDET_AVG_EN` defined:
  - sums 4 consecutive accepted periods into a PERIOD_W+2-bit accumulator;
  - divides 2^34 by the sum (32 quotient bits, 32 cycles);
  - `period_out` = sum>>2.
  - A discarded, overflowed or dropped period resets the accumulation, and 4 fresh periods are needed before the next `valid_out`.
- Undefined: single-period estimate as described above.

## Test plan
- Ramp −128..127, +1 per step, continuous strobes, 3 wraps → `valid_out` ×2, `period_out` = 256, `phase_incr_out` = 0x01000000, `locked_out` = 1; `valid_out` exactly 33 cycles after each wrap step.
- Synthetic sawtooth wrapping every 100 steps, `step_in` every 4th cycle → `phase_incr_out` = 42949672 (0x028F5C28), `period_out` = 100.
- MIN_PERIOD = 4, wraps every 3 steps after a locked measurement → no `valid_out`, `locked_out` falls at the first short wrap, outputs unchanged.
- PERIOD_W = 8, 300 steps with no wrap, then a wrap → `locked_out` low once `cnt` reaches 255, `overflow_out` pulse at the wrap, no `valid_out`.
- `rst_in` low for 1 cycle 10 cycles into DIVIDE → all outputs 0, no `valid_out`; the next valid estimate requires two new wraps.
- `SAWDET_AVG_EN`, periods 100, 100, 101, 101 → single `valid_out`, `phase_incr_out` = 42735992, `period_out` = 100.
